machine_ctl: RTL and testbench
==============================

MACHINE_CTL -- requirements
Module: machine_ctl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock; all state updates on posedge clk.
REQ-002 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-003 SHALL have port fetch, input, 1, cycle-start enable from the clock generator.
REQ-004 SHALL have port opcode, input, 3, instruction opcode from the instruction register.
REQ-005 SHALL have port zero, input, 1, accumulator-is-zero flag.
REQ-006 SHALL have ports inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, output, 1 each, registered control strobes.
REQ-007 SHALL have port halt, output, 1, registered halt indication.

Function
REQ-008 SHALL hold an enable flag ena; while ena=0, the state is S0 and all outputs are 0.
REQ-009 SHALL set ena at an edge with ena=0 and fetch=1, loading state S0 and the S0 output row at the same edge.
REQ-010 SHALL keep ena=1 regardless of later fetch values until reset.
REQ-011 SHALL advance the state one step per edge while ena=1, in the order S0 to S7, then wrap from S7 to S0.
REQ-012 SHALL register all outputs so that, in the cycle the state is Sn, the outputs equal the Sn row; any strobe not listed for a row is 0.
REQ-013 SHALL sample opcode and zero into internal registers at the S2-to-S3 edge.
REQ-014 SHALL decode the S3 row from the live opcode at that edge, and decode the S4-S7 rows from the latched values.
REQ-015 Opcode encoding: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111; ALU class = ADD/AND/XOR/LDA.
REQ-016 S0 row SHALL be rd=1 and load_ir=1.
REQ-017 S1 row SHALL be rd=1, load_ir=1 and inc_pc=1.
REQ-018 S2 row SHALL be all outputs 0.
REQ-019 S3 row SHALL be inc_pc=1; for HLT it SHALL additionally be halt=1.
REQ-020 S4 row SHALL be: ALU class rd=1; JMP load_pc=1; STO datactl_ena=1.
REQ-021 S5 row SHALL be: ALU class rd=1 and load_acc=1; SKZ with zero=1 inc_pc=1; JMP load_pc=1 and inc_pc=1; STO datactl_ena=1.
REQ-022 S6 row SHALL be: ALU class rd=1; STO wr=1 and datactl_ena=1.
REQ-023 S7 row SHALL be: SKZ with zero=1 inc_pc=1; STO datactl_ena=1.
REQ-024 SHALL never assert rd and wr in the same cycle.
REQ-025 SHALL never assert load_acc and load_pc in the same cycle.
REQ-026 SHALL ignore opcode and zero changes outside the S2-to-S3 edge.

Reset
REQ-027 reset=0 at any edge SHALL force state=S0, ena=0, latched opcode=000, latched zero=0, halted flag=0, and all outputs=0, overriding fetch and any in-progress cycle.
REQ-028 After reset is released, the block SHALL stay idle until fetch=1 is sampled, per REQ-009.

Configuration
REQ-029 Macro CTL_HALT_LATCH_EN SHALL select halt behaviour.
REQ-030 With CTL_HALT_LATCH_EN defined, after a HLT S3 cycle the block SHALL enter a HALTED state.
REQ-031 In HALTED, halt SHALL stay 1, all other strobes SHALL be 0, and fetch SHALL be ignored, until reset.
REQ-032 Without CTL_HALT_LATCH_EN, halt SHALL be a single-cycle pulse in S3 and the FSM SHALL continue to S4-S7 with all strobes 0 for HLT.

Verification
REQ-033 Startup: hold reset=0 for 2 cycles, then reset=1 and fetch=1 at edge E -> from E+1, rows S0..S7 appear once per cycle and S0 repeats at E+9.
REQ-034 LDA: opcode=101 at the S2-to-S3 edge -> rd=1 in S4-S6, load_acc=1 only in S5, inc_pc=1 in S1 and S3, wr never asserted.
REQ-035 STO: opcode=110 -> datactl_ena=1 in S4-S7, wr=1 only in S6, rd=0 in S4-S7.
REQ-036 SKZ: zero=1 -> inc_pc=1 in S1, S3, S5 and S7; zero=0 -> inc_pc=1 in S1 and S3 only.
REQ-036a Opcode change: switch opcode 110->111 during S4 -> rows still follow STO.
REQ-037 HLT with macro defined: halt=1 from S3 onward indefinitely with other strobes 0; apply reset=0 for 1 edge -> halt=0; then fetch=1 restarts at S0.
REQ-038 Mid-cycle reset: reset=0 at the S5 edge of an ADD -> all outputs 0 at the next cycle; the FSM restarts at S0 only after fetch=1 is sampled.

Source files
------------

// File: rtl/machine_ctl.sv
// machine_ctl: eight-phase instruction-cycle controller.
// A fetch pulse arms the controller; it then walks S0..S7 forever, emitting
// one registered row of control strobes per state. The opcode and zero flag
// are captured at the S2->S3 edge so later rows ignore bus changes.
// Optional feature macro: CTL_HALT_LATCH_EN -- when defined, a HLT opcode
// parks the controller in HALTED (halt held high) until reset; otherwise halt
// is a one-cycle pulse in S3 and the cycle runs on with idle rows.
module machine_ctl (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_acc,
  output logic       load_pc,
  output logic       rd,
  output logic       wr,
  output logic       load_ir,
  output logic       datactl_ena,
  output logic       halt
);

  typedef enum logic [3:0] {S0, S1, S2, S3, S4, S5, S6, S7, HALTED} state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
    logic halt;
  } ctl_t;

  localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010, AND = 3'b011,
                         XOR = 3'b100, LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

  state_t     state, nxt_state;
  logic       ena, nxt_ena;
  logic [2:0] op_q, op_sel;
  logic       zero_q;
  logic       alu, is_sto, is_jmp, skip;
  ctl_t       ctl, nxt_ctl;

  // State register, enable flag, opcode/zero capture and registered strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= S0;
      ena    <= 1'b0;
      op_q   <= HLT;
      zero_q <= 1'b0;
      ctl    <= '0;
    end else begin
      state <= nxt_state;
      ena   <= nxt_ena;
      ctl   <= nxt_ctl;
      if (ena && state == S2) begin
        op_q   <= opcode;
        zero_q <= zero;
      end
    end
  end

  // Next state plus the output row of that next state, so rows line up with states
  always_comb begin
    nxt_state = state;
    nxt_ena   = ena;
    nxt_ctl   = '0;
    if (!ena) begin
      nxt_state = S0;
      nxt_ena   = fetch;
    end else begin
      case (state)
        S0:      nxt_state = S1;
        S1:      nxt_state = S2;
        S2:      nxt_state = S3;
`ifdef CTL_HALT_LATCH_EN
        S3:      nxt_state = (op_q == HLT) ? HALTED : S4;
`else
        S3:      nxt_state = S4;
`endif
        S4:      nxt_state = S5;
        S5:      nxt_state = S6;
        S6:      nxt_state = S7;
        S7:      nxt_state = S0;
        HALTED:  nxt_state = HALTED;
        default: nxt_state = S0;
      endcase
    end

    // S3 decodes the opcode being captured on this edge; later rows use the capture
    op_sel = (nxt_state == S3) ? opcode : op_q;
    alu    = (op_sel == ADD) || (op_sel == AND) || (op_sel == XOR) || (op_sel == LDA);
    is_sto = (op_sel == STO);
    is_jmp = (op_sel == JMP);
    skip   = (op_sel == SKZ) && zero_q;

    if (nxt_ena) begin
      case (nxt_state)
        S0: begin
          nxt_ctl.rd      = 1'b1;
          nxt_ctl.load_ir = 1'b1;
        end
        S1: begin
          nxt_ctl.rd      = 1'b1;
          nxt_ctl.load_ir = 1'b1;
          nxt_ctl.inc_pc  = 1'b1;
        end
        S3: begin
          nxt_ctl.inc_pc = 1'b1;
          nxt_ctl.halt   = (op_sel == HLT);
        end
        S4: begin
          nxt_ctl.rd          = alu;
          nxt_ctl.load_pc     = is_jmp;
          nxt_ctl.datactl_ena = is_sto;
        end
        S5: begin
          nxt_ctl.rd          = alu;
          nxt_ctl.load_acc    = alu;
          nxt_ctl.inc_pc      = skip || is_jmp;
          nxt_ctl.load_pc     = is_jmp;
          nxt_ctl.datactl_ena = is_sto;
        end
        S6: begin
          nxt_ctl.rd          = alu;
          nxt_ctl.wr          = is_sto;
          nxt_ctl.datactl_ena = is_sto;
        end
        S7: begin
          nxt_ctl.inc_pc      = skip;
          nxt_ctl.datactl_ena = is_sto;
        end
        HALTED:  nxt_ctl.halt = 1'b1;
        default: nxt_ctl = '0;
      endcase
    end
  end

  assign inc_pc      = ctl.inc_pc;
  assign load_acc    = ctl.load_acc;
  assign load_pc     = ctl.load_pc;
  assign rd          = ctl.rd;
  assign wr          = ctl.wr;
  assign load_ir     = ctl.load_ir;
  assign datactl_ena = ctl.datactl_ena;
  assign halt        = ctl.halt;

endmodule

// File: tb/tb_machine_ctl.sv
// Directed vector bench for machine_ctl. Each vector is one clock: inputs are
// driven on the falling edge, outputs checked 1 ns after the rising edge.
// Row bit order: {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt}.
module tb_machine_ctl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fetch = 1'b0;
  logic [2:0] opcode = 3'b000;
  logic       zero = 1'b0;
  logic       inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt;

  int checks = 0;
  int fails  = 0;

  machine_ctl dut (
    .clk(clk), .reset(reset), .fetch(fetch), .opcode(opcode), .zero(zero),
    .inc_pc(inc_pc), .load_acc(load_acc), .load_pc(load_pc), .rd(rd), .wr(wr),
    .load_ir(load_ir), .datactl_ena(datactl_ena), .halt(halt)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] Z    = 8'b0000_0000;
  localparam logic [7:0] R0   = 8'b0001_0100;
  localparam logic [7:0] R1   = 8'b1001_0100;
  localparam logic [7:0] R3   = 8'b1000_0000;
  localparam logic [7:0] R3H  = 8'b1000_0001;
  localparam logic [7:0] ALU4 = 8'b0001_0000;
  localparam logic [7:0] ALU5 = 8'b0101_0000;
  localparam logic [7:0] ALU6 = 8'b0001_0000;
  localparam logic [7:0] STO4 = 8'b0000_0010;
  localparam logic [7:0] STO6 = 8'b0000_1010;
  localparam logic [7:0] JMP4 = 8'b0010_0000;
  localparam logic [7:0] JMP5 = 8'b1010_0000;
  localparam logic [7:0] INC  = 8'b1000_0000;
  localparam logic [7:0] HLTQ = 8'b0000_0001;

  typedef struct {
    logic       rst;
    logic       fch;
    logic [2:0] op;
    logic       z;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] outs();
    return {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt};
  endfunction

  task automatic step(input logic r, input logic f, input logic [2:0] op,
                      input logic z, input logic [7:0] exp, input string name);
    logic [7:0] got;
    @(negedge clk);
    reset = r; fetch = f; opcode = op; zero = z;
    @(posedge clk);
    #1;
    got = outs();
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: outputs=%b expected=%b", name, got, exp);
    end
    checks++;
    if ((rd && wr) || (load_acc && load_pc)) begin
      fails++;
      $display("FAIL %s exclusivity: outputs=%b expected no rd&wr / load_acc&load_pc", name, got);
    end
  endtask

  initial begin
    // reset and startup, then LDA with an opcode change after capture
    tbl.push_back('{0, 0, 3'd0, 0, Z});
    tbl.push_back('{0, 1, 3'd0, 0, Z});     // reset beats fetch
    tbl.push_back('{1, 0, 3'd0, 0, Z});     // idle until fetch
    tbl.push_back('{1, 1, 3'd5, 0, R0});
    tbl.push_back('{1, 0, 3'd5, 0, R1});
    tbl.push_back('{1, 0, 3'd5, 0, Z});
    tbl.push_back('{1, 0, 3'd5, 0, R3});    // LDA captured
    tbl.push_back('{1, 0, 3'd6, 1, ALU4});  // later changes ignored
    tbl.push_back('{1, 0, 3'd6, 1, ALU5});
    tbl.push_back('{1, 0, 3'd6, 1, ALU6});
    tbl.push_back('{1, 0, 3'd6, 1, Z});
    tbl.push_back('{1, 0, 3'd6, 1, R0});    // wrap, fetch low, still running
    // STO, opcode switched to JMP during S4
    tbl.push_back('{1, 0, 3'd6, 0, R1});
    tbl.push_back('{1, 0, 3'd6, 0, Z});
    tbl.push_back('{1, 0, 3'd6, 0, R3});
    tbl.push_back('{1, 0, 3'd7, 0, STO4});
    tbl.push_back('{1, 0, 3'd7, 0, STO4});
    tbl.push_back('{1, 0, 3'd7, 0, STO6});
    tbl.push_back('{1, 0, 3'd7, 0, STO4});
    tbl.push_back('{1, 0, 3'd1, 1, R0});
    // SKZ with zero=1 captured, zero dropped afterwards
    tbl.push_back('{1, 0, 3'd1, 1, R1});
    tbl.push_back('{1, 0, 3'd1, 1, Z});
    tbl.push_back('{1, 0, 3'd1, 1, R3});
    tbl.push_back('{1, 0, 3'd1, 0, Z});
    tbl.push_back('{1, 0, 3'd1, 0, INC});
    tbl.push_back('{1, 0, 3'd1, 0, Z});
    tbl.push_back('{1, 0, 3'd1, 0, INC});
    tbl.push_back('{1, 0, 3'd1, 0, R0});
    // SKZ with zero=0 captured, zero raised afterwards
    tbl.push_back('{1, 0, 3'd1, 0, R1});
    tbl.push_back('{1, 0, 3'd1, 0, Z});
    tbl.push_back('{1, 0, 3'd1, 0, R3});
    tbl.push_back('{1, 0, 3'd1, 1, Z});
    tbl.push_back('{1, 0, 3'd1, 1, Z});
    tbl.push_back('{1, 0, 3'd1, 1, Z});
    tbl.push_back('{1, 0, 3'd1, 1, Z});
    tbl.push_back('{1, 0, 3'd7, 1, R0});
    // JMP
    tbl.push_back('{1, 0, 3'd7, 0, R1});
    tbl.push_back('{1, 0, 3'd7, 0, Z});
    tbl.push_back('{1, 0, 3'd7, 0, R3});
    tbl.push_back('{1, 0, 3'd7, 0, JMP4});
    tbl.push_back('{1, 0, 3'd7, 0, JMP5});
    tbl.push_back('{1, 0, 3'd7, 0, Z});
    tbl.push_back('{1, 0, 3'd7, 0, Z});
    tbl.push_back('{1, 0, 3'd2, 0, R0});
    // ADD interrupted by reset on the S5 edge
    tbl.push_back('{1, 0, 3'd2, 0, R1});
    tbl.push_back('{1, 0, 3'd2, 0, Z});
    tbl.push_back('{1, 0, 3'd2, 0, R3});
    tbl.push_back('{1, 0, 3'd2, 0, ALU4});
    tbl.push_back('{0, 0, 3'd2, 0, Z});
    tbl.push_back('{1, 0, 3'd2, 0, Z});
    tbl.push_back('{1, 0, 3'd2, 0, Z});
    tbl.push_back('{1, 1, 3'd0, 0, R0});

    foreach (tbl[i])
      step(tbl[i].rst, tbl[i].fch, tbl[i].op, tbl[i].z, tbl[i].exp, $sformatf("vec%0d", i));

    // HLT cycle
    step(1, 0, 3'd0, 0, R1,  "hlt_s1");
    step(1, 0, 3'd0, 0, Z,   "hlt_s2");
    step(1, 0, 3'd0, 0, R3H, "hlt_s3");
`ifdef CTL_HALT_LATCH_EN
    for (int i = 0; i < 10; i++)
      step(1, i[0], 3'd2, 1, HLTQ, $sformatf("halted%0d", i));
    step(0, 1, 3'd2, 0, Z,  "halt_reset");
    step(1, 0, 3'd2, 0, Z,  "halt_idle");
    step(1, 1, 3'd2, 0, R0, "halt_restart_s0");
    step(1, 0, 3'd2, 0, R1, "halt_restart_s1");
`else
    step(1, 1, 3'd2, 1, Z,  "hlt_s4");
    step(1, 1, 3'd2, 1, Z,  "hlt_s5");
    step(1, 0, 3'd2, 1, Z,  "hlt_s6");
    step(1, 0, 3'd2, 1, Z,  "hlt_s7");
    step(1, 0, 3'd2, 1, R0, "hlt_wrap_s0");
    step(1, 0, 3'd2, 1, R1, "hlt_wrap_s1");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
